// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the sram_4kb_256x128x8 peripheral sequencer:
// array geometry, default access timing, FSM state type, counter width
// helper and the request-address split (row in MSBs, column group in LSBs).
package sram_ctrl_pkg;

  localparam int unsigned ROWS   = 256;
  localparam int unsigned COLS   = 128;
  localparam int unsigned MUX    = 8;
  localparam int unsigned WORD_W = COLS / MUX;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(MUX);
  localparam int unsigned ADDR_W = ROW_W + COL_W;

  localparam int unsigned PRE_CYC_DEF   = 2;
  localparam int unsigned WL_CYC_DEF    = 2;
  localparam int unsigned SENSE_CYC_DEF = 1;

  // Bits needed to hold the largest per-state cycle count.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(PRE_CYC_DEF, WL_CYC_DEF, SENSE_CYC_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACCESS,
    ST_SENSE,
    ST_WRITE,
    ST_WR_HOLD,
    ST_RECOVER
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] a);
    addr_split_t s;
    s.row = a[ADDR_W-1:COL_W];
    s.col = a[COL_W-1:0];
    return s;
  endfunction

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Request/response port of the SRAM sequencer.
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_we/addr/wdata   : request type, {row, col group} address, write data
//   rsp_valid/we/rdata  : one-cycle completion pulse, op type, read data
// master = requester (DPE-side logic), slave = sram_array_ctrl.
interface sram_array_ctrl_if
  import sram_ctrl_pkg::*;
();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_we;
  logic [WORD_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter shared by all sequencer states.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (entering a timed state)
//   load_val  : cycle count for the state being entered
//   done      : current cycle is the last one of the timed state
module sram_ctrl_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/sram_array_ctrl.sv
// Peripheral sequencer for the sram_4kb_256x128x8 macro.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request/response port (sram_array_ctrl_if.slave)
//   wl_row     : row to the decoder        wl_en    : wordline enable
//   col_sel    : column mux select         prech_n  : active-low precharge
//   write_en   : global write enable       sense_en : sense-amp fire
//   wr_bl_low  : pull BL low (write 0)     wr_bln_low : pull BLN low (write 1)
//   sa_data    : sense-amp outputs, valid while sense_en is high
// Read:  PRECHARGE -> ACCESS -> SENSE -> RECOVER -> IDLE
// Write: PRECHARGE -> WRITE -> WR_HOLD -> IDLE
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned PRE_CYC   = PRE_CYC_DEF,
  parameter int unsigned WL_CYC    = WL_CYC_DEF,
  parameter int unsigned SENSE_CYC = SENSE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_array_ctrl_if.slave  bus,
  output logic [ROW_W-1:0]  wl_row,
  output logic              wl_en,
  output logic [COL_W-1:0]  col_sel,
  output logic              prech_n,
  output logic              write_en,
  output logic [WORD_W-1:0] wr_bl_low,
  output logic [WORD_W-1:0] wr_bln_low,
  output logic              sense_en,
  input  logic [WORD_W-1:0] sa_data
);

  localparam int unsigned CW = cnt_width(PRE_CYC, WL_CYC, SENSE_CYC);

  state_t            state, state_next;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q, rsp_valid_q, rsp_we_q;

  logic              tmr_load, tmr_done;
  logic [CW-1:0]     tmr_val;

  logic              accept, capture;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [WORD_W-1:0] nxt_wdata, nxt_rdata;
  logic              nxt_ready, nxt_rsp_valid, nxt_rsp_we;
  logic              nxt_wl_en, nxt_prech_n, nxt_write_en, nxt_sense_en;
  logic [WORD_W-1:0] nxt_bl_low, nxt_bln_low;
  logic [ROW_W-1:0]  nxt_row;
  logic [COL_W-1:0]  nxt_col;
  addr_split_t       nxt_split;

  sram_ctrl_timer #(.CNT_W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Array-side outputs are decoded from the *next* state and registered,
  // so they change on the same edge as the state and never see req_* directly.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    accept     = 1'b0;
    capture    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = ST_PRECHARGE;
          tmr_load   = 1'b1;
          tmr_val    = CW'(PRE_CYC);
        end
      end
      ST_PRECHARGE: begin
        if (tmr_done) begin
          state_next = we_q ? ST_WRITE : ST_ACCESS;
          tmr_load   = 1'b1;
          tmr_val    = CW'(WL_CYC);
        end
      end
      ST_ACCESS: begin
        if (tmr_done) begin
          state_next = ST_SENSE;
          tmr_load   = 1'b1;
          tmr_val    = CW'(SENSE_CYC);
        end
      end
      ST_SENSE: begin
        if (tmr_done) begin
          state_next = ST_RECOVER;
          capture    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (tmr_done)
          state_next = ST_WR_HOLD;
      end
      ST_WR_HOLD: state_next = ST_IDLE;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    nxt_we    = accept ? bus.req_we    : we_q;
    nxt_addr  = accept ? bus.req_addr  : addr_q;
    nxt_wdata = accept ? bus.req_wdata : wdata_q;
    nxt_rdata = capture ? sa_data : rdata_q;
    nxt_split = split_addr(nxt_addr);

    nxt_ready     = (state_next == ST_IDLE);
    nxt_prech_n   = (state_next != ST_PRECHARGE);
    nxt_wl_en     = (state_next == ST_ACCESS) || (state_next == ST_SENSE) ||
                    (state_next == ST_WRITE);
    nxt_sense_en  = (state_next == ST_SENSE);
    // Drivers stay on through WR_HOLD so the wordline closes first.
    nxt_write_en  = (state_next == ST_WRITE) || (state_next == ST_WR_HOLD);
    nxt_bl_low    = nxt_write_en ? ~nxt_wdata : '0;
    nxt_bln_low   = nxt_write_en ?  nxt_wdata : '0;
    nxt_rsp_valid = (state_next == ST_RECOVER) || (state_next == ST_WR_HOLD);
    nxt_rsp_we    = (state_next == ST_WR_HOLD);
    nxt_row       = (state_next != ST_IDLE) ? nxt_split.row : '0;
    nxt_col       = (state_next != ST_IDLE) ? nxt_split.col : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      wl_row      <= '0;
      col_sel     <= '0;
      wl_en       <= 1'b0;
      prech_n     <= 1'b1;
      write_en    <= 1'b0;
      sense_en    <= 1'b0;
      wr_bl_low   <= '0;
      wr_bln_low  <= '0;
    end else begin
      state       <= state_next;
      we_q        <= nxt_we;
      addr_q      <= nxt_addr;
      wdata_q     <= nxt_wdata;
      rdata_q     <= nxt_rdata;
      ready_q     <= nxt_ready;
      rsp_valid_q <= nxt_rsp_valid;
      rsp_we_q    <= nxt_rsp_we;
      wl_row      <= nxt_row;
      col_sel     <= nxt_col;
      wl_en       <= nxt_wl_en;
      prech_n     <= nxt_prech_n;
      write_en    <= nxt_write_en;
      sense_en    <= nxt_sense_en;
      wr_bl_low   <= nxt_bl_low;
      wr_bln_low  <= nxt_bln_low;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: one instance with default timing (directed
// cases), one with PRE_CYC=1/WL_CYC=3/SENSE_CYC=2 (random traffic).
// Each instance drives a simple bitcell-array emulation that supplies sa_data.
module tb_sram_array_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, sel;
  logic req_valid, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  sram_array_ctrl_if a_if ();
  sram_array_ctrl_if b_if ();

  assign a_if.req_valid = req_valid & ~sel;
  assign b_if.req_valid = req_valid &  sel;
  assign a_if.req_we    = req_we;
  assign b_if.req_we    = req_we;
  assign a_if.req_addr  = req_addr;
  assign b_if.req_addr  = req_addr;
  assign a_if.req_wdata = req_wdata;
  assign b_if.req_wdata = req_wdata;

  logic [ROW_W-1:0]  row_a, row_b;
  logic [COL_W-1:0]  col_a, col_b;
  logic              wl_a, wl_b, pre_a, pre_b, we_a, we_b, se_a, se_b;
  logic [WORD_W-1:0] bl_a, bl_b, bln_a, bln_b, sa_a, sa_b, noise;

  sram_array_ctrl u_a (
    .clk(clk), .rst(rst_a), .bus(a_if), .wl_row(row_a), .wl_en(wl_a),
    .col_sel(col_a), .prech_n(pre_a), .write_en(we_a), .wr_bl_low(bl_a),
    .wr_bln_low(bln_a), .sense_en(se_a), .sa_data(sa_a)
  );

  sram_array_ctrl #(.PRE_CYC(1), .WL_CYC(3), .SENSE_CYC(2)) u_b (
    .clk(clk), .rst(rst_b), .bus(b_if), .wl_row(row_b), .wl_en(wl_b),
    .col_sel(col_b), .prech_n(pre_b), .write_en(we_b), .wr_bl_low(bl_b),
    .wr_bln_low(bln_b), .sense_en(se_b), .sa_data(sa_b)
  );

  // Bitcell emulation: cells flip while wordline and drivers are both on;
  // sense amps show cell contents only while fired, junk otherwise.
  logic [WORD_W-1:0] cells_a [2**ADDR_W];
  logic [WORD_W-1:0] cells_b [2**ADDR_W];
  always @(posedge clk) begin
    if (wl_a && we_a) cells_a[{row_a, col_a}] <= (cells_a[{row_a, col_a}] & ~bl_a) | bln_a;
    if (wl_b && we_b) cells_b[{row_b, col_b}] <= (cells_b[{row_b, col_b}] & ~bl_b) | bln_b;
  end
  always @(negedge clk) noise <= WORD_W'($urandom);
  assign sa_a = se_a ? cells_a[{row_a, col_a}] : noise;
  assign sa_b = se_b ? cells_b[{row_b, col_b}] : noise;

  // Selected-instance views
  wire              v_ready = sel ? b_if.req_ready : a_if.req_ready;
  wire              v_rsp   = sel ? b_if.rsp_valid : a_if.rsp_valid;
  wire              v_rwe   = sel ? b_if.rsp_we    : a_if.rsp_we;
  wire [WORD_W-1:0] v_rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
  wire [ROW_W-1:0]  v_row   = sel ? row_b : row_a;
  wire [COL_W-1:0]  v_col   = sel ? col_b : col_a;
  wire              v_wl    = sel ? wl_b  : wl_a;
  wire              v_pre   = sel ? pre_b : pre_a;
  wire              v_we    = sel ? we_b  : we_a;
  wire [WORD_W-1:0] v_bl    = sel ? bl_b  : bl_a;
  wire [WORD_W-1:0] v_bln   = sel ? bln_b : bln_a;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Electrical invariants on both instances, every cycle.
  always @(negedge clk) begin
    if (se_a && we_a) viol <= viol + 1;
    if (se_b && we_b) viol <= viol + 1;
    if (wl_a && !pre_a) viol <= viol + 1;
    if (wl_b && !pre_b) viol <= viol + 1;
    if ((bl_a & bln_a) != '0) viol <= viol + 1;
    if ((bl_b & bln_b) != '0) viol <= viol + 1;
  end

  // Per-transaction observations
  int                t_prech;
  logic              t_ready_early, t_rdy_after;
  logic [WORD_W-1:0] t_bl, t_bln;
  logic [ROW_W-1:0]  t_row;
  logic [COL_W-1:0]  t_col;

  // lat = cycle index of rsp_valid, counting the accept cycle as T0.
  task automatic xact(input logic b, input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [WORD_W-1:0] wd, output int lat,
                      output logic rwe, output logic [WORD_W-1:0] rdata);
    int guard;
    sel = b;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    guard = 0;
    while (!v_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; t_prech = 0; t_ready_early = 1'b0;
    t_bl = '0; t_bln = '0; t_row = '0; t_col = '0;
    while (1) begin
      if (!v_pre) t_prech++;
      if (v_we && v_wl) begin t_bl = v_bl; t_bln = v_bln; end
      if (v_wl) begin t_row = v_row; t_col = v_col; end
      if (v_rsp || lat >= 30) break;
      if (v_ready) t_ready_early = 1'b1;
      @(posedge clk); #1 lat++;
    end
    rwe = v_rwe; rdata = v_rdata;
    @(posedge clk); #1 t_rdy_after = v_ready;
  endtask

  logic [WORD_W-1:0] ref_b [2**ADDR_W];
  logic [ADDR_W-1:0] pool [8];
  logic [ADDR_W-1:0] b2b_addr [4];
  logic [WORD_W-1:0] b2b_exp [4];
  logic [WORD_W-1:0] got_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, accepts, prech;
    logic rwe, we;
    logic [WORD_W-1:0] rd, wd;
    logic [ADDR_W-1:0] ad;

    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   32'(a_if.req_ready), 32'd1);
    check("rst_prech_n", 32'(pre_a),          32'd1);
    check("rst_wl_en",   32'(wl_a),           32'd0);
    check("rst_write",   32'({we_a, se_a, a_if.rsp_valid}), 32'd0);
    check("rst_rdata",   32'(a_if.rsp_rdata), 32'd0);
    check("rst_drivers", 32'({bl_a, bln_a}),  32'd0);
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;

    // Write then read address 0
    xact(1'b0, 1'b1, 11'h000, 16'hA5C3, lat, rwe, rd);
    check("wr0_lat", 32'(lat), 32'd5);
    check("wr0_rsp_we", 32'(rwe), 32'd1);
    check("wr0_bl_low", 32'(t_bl), 32'h5A3C);
    check("wr0_bln_low", 32'(t_bln), 32'hA5C3);
    check("wr0_ready_busy", 32'(t_ready_early), 32'd0);
    check("wr0_prech_cycles", 32'(t_prech), 32'd2);
    check("wr0_ready_after", 32'(t_rdy_after), 32'd1);
    xact(1'b0, 1'b0, 11'h000, '0, lat, rwe, rd);
    check("rd0_lat", 32'(lat), 32'd6);
    check("rd0_rsp_we", 32'(rwe), 32'd0);
    check("rd0_data", 32'(rd), 32'hA5C3);
    check("rd0_ready_busy", 32'(t_ready_early), 32'd0);

    // Same row, column 7 vs column 0
    xact(1'b0, 1'b1, 11'h7FF, 16'hFFFF, lat, rwe, rd);
    check("wr7ff_row", 32'(t_row), 32'd255);
    check("wr7ff_bln", 32'(t_bln), 32'hFFFF);
    xact(1'b0, 1'b1, 11'h7F8, 16'h0000, lat, rwe, rd);
    check("wr7f8_bl", 32'(t_bl), 32'hFFFF);
    xact(1'b0, 1'b0, 11'h7FF, '0, lat, rwe, rd);
    check("rd7ff_col", 32'(t_col), 32'd7);
    check("rd7ff_row", 32'(t_row), 32'd255);
    check("rd7ff_data", 32'(rd), 32'hFFFF);
    xact(1'b0, 1'b0, 11'h7F8, '0, lat, rwe, rd);
    check("rd7f8_col", 32'(t_col), 32'd0);
    check("rd7f8_row", 32'(t_row), 32'd255);
    check("rd7f8_data", 32'(rd), 32'h0000);
    check("rd0_still", 32'(cells_a[0]), 32'hA5C3);

    // Four reads with req_valid held high throughout
    b2b_addr[0] = 11'h000; b2b_exp[0] = 16'hA5C3;
    b2b_addr[1] = 11'h7FF; b2b_exp[1] = 16'hFFFF;
    b2b_addr[2] = 11'h7F8; b2b_exp[2] = 16'h0000;
    b2b_addr[3] = 11'h000; b2b_exp[3] = 16'hA5C3;
    sel = 1'b0; accepts = 0; prech = 0; got_q.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (a_if.rsp_valid) got_q.push_back(a_if.rsp_rdata);
      if (!pre_a) prech++;
      if (accepts < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = b2b_addr[accepts];
        if (a_if.req_ready) accepts++;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_rsp_count", 32'(got_q.size()), 32'd4);
    check("b2b_prech_cycles", 32'(prech), 32'd8);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check($sformatf("b2b_data%0d", i), 32'(got_q[i]), 32'(b2b_exp[i]));

    // Reset in the first WRITE cycle
    xact(1'b0, 1'b1, 11'h123, 16'h1357, lat, rwe, rd);
    @(negedge clk);
    req_we = 1'b1; req_addr = 11'h123; req_wdata = 16'h1357; req_valid = 1'b1;
    for (int g = 0; g < 50 && !a_if.req_ready; g++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstw_in_write", 32'({wl_a, we_a}), 32'd3);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("rstw_wl_en", 32'(wl_a), 32'd0);
    check("rstw_write_en", 32'(we_a), 32'd0);
    check("rstw_drivers", 32'({bl_a, bln_a}), 32'd0);
    check("rstw_prech_n", 32'(pre_a), 32'd1);
    check("rstw_ready", 32'(a_if.req_ready), 32'd1);
    check("rstw_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
    @(negedge clk); rst_a = 1'b0;
    xact(1'b0, 1'b0, 11'h123, '0, lat, rwe, rd);
    check("rstw_rd_lat", 32'(lat), 32'd6);
    check("rstw_rd_data", 32'(rd), 32'h1357);

    // Random traffic on the PRE=1/WL=3/SENSE=2 instance
    pool[0] = 11'h000; pool[1] = 11'h7FF;
    for (int i = 2; i < 8; i++) pool[i] = ADDR_W'($urandom);
    for (int i = 0; i < 8; i++) begin
      wd = WORD_W'($urandom);
      xact(1'b1, 1'b1, pool[i], wd, lat, rwe, rd);
      ref_b[pool[i]] = wd;
      check("b_init_wr_lat", 32'(lat), 32'd5);
    end
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      ad = pool[$urandom_range(0, 7)];
      wd = WORD_W'($urandom);
      xact(1'b1, we, ad, wd, lat, rwe, rd);
      check(we ? "b_wr_lat" : "b_rd_lat", 32'(lat), we ? 32'd5 : 32'd7);
      check("b_rsp_we", 32'(rwe), 32'(we));
      if (we) ref_b[ad] = wd;
      else    check("b_rd_data", 32'(rd), 32'(ref_b[ad]));
    end

    @(negedge clk);
    check("invariants", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
